// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the M-extension execution unit: operand width,
// FUN3 operation encodings and the control state encoding.
package mul_div_unit_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    F_MUL    = 3'b000,
    F_MULH   = 3'b001,
    F_MULHSU = 3'b010,
    F_MULHU  = 3'b011,
    F_DIV    = 3'b100,
    F_DIVU   = 3'b101,
    F_REM    = 3'b110,
    F_REMU   = 3'b111
  } fun3_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Execute-stage handshake between the pipeline (master) and the mul/div unit (slave).
interface mul_div_unit_if;
  import mul_div_unit_pkg::*;

  logic            START;
  logic [2:0]      FUN3;
  logic [XLEN-1:0] RS1;
  logic [XLEN-1:0] RS2;
  logic            STALL;
  logic            FLUSH;
  logic            BUSY;
  logic            DONE;
  logic [XLEN-1:0] RESULT;

  modport master (
    output START, FUN3, RS1, RS2, STALL, FLUSH,
    input  BUSY, DONE, RESULT
  );

  modport slave (
    input  START, FUN3, RS1, RS2, STALL, FLUSH,
    output BUSY, DONE, RESULT
  );

endinterface

// File: rtl/mul_div_unit_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per step,
// remainder in the upper half and quotient in the lower half of a shift register.
module div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            last_o
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   dsr_q;
  logic [5:0]        cnt_q;
  logic [XLEN:0]     part;
  logic [XLEN:0]     diff;

  // Partial remainder after the shift needs XLEN+1 bits; a borrow means "restore".
  always_comb begin
    part = acc_q[2*XLEN-1:XLEN-1];
    diff = part - {1'b0, dsr_q};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      acc_q <= {{XLEN{1'b0}}, dividend_i};
      dsr_q <= divisor_i;
      cnt_q <= '0;
    end else if (step_i) begin
      if (diff[XLEN]) acc_q <= {acc_q[2*XLEN-2:0], 1'b0};
      else            acc_q <= {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      cnt_q <= cnt_q + 6'd1;
    end
  end

  assign quotient_o  = acc_q[XLEN-1:0];
  assign remainder_o = acc_q[2*XLEN-1:XLEN];
  assign last_o      = (cnt_q == 6'd31);

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32 M-extension unit: 2-cycle multiply, 34-cycle divide/remainder,
// 1-cycle fast path for divide-by-zero and signed overflow.
module mul_div_unit #(
  parameter int unsigned XLEN = mul_div_unit_pkg::XLEN
) (
  input logic                 CLK,
  input logic                 RST,
  mul_div_unit_if.slave       bus
);
  import mul_div_unit_pkg::*;

  state_e          state_q;
  fun3_e           op_q;
  logic [XLEN-1:0] a_q, b_q, result_q, result_d;
  logic            busy_q, done_q;

  logic            sdiv_in, div_zero, sdiv_ovf, fast;
  logic [XLEN-1:0] dvd_mag, dsr_mag, fast_res;
  logic [XLEN:0]   mul_a, mul_b;
  logic [2*XLEN-1:0] ext_a, ext_b, prod;
  logic [XLEN-1:0] mul_res, quot, rem, q_fix, r_fix, fix_res;
  logic            div_last, accept;

  always_comb begin
    sdiv_in  = !bus.FUN3[0];
    div_zero = (bus.RS2 == '0);
    sdiv_ovf = sdiv_in && (bus.RS1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.RS2 == '1);
    fast     = div_zero || sdiv_ovf;
    dvd_mag  = (sdiv_in && bus.RS1[XLEN-1]) ? -bus.RS1 : bus.RS1;
    dsr_mag  = (sdiv_in && bus.RS2[XLEN-1]) ? -bus.RS2 : bus.RS2;
    if (div_zero) fast_res = bus.FUN3[1] ? bus.RS1 : '1;
    else          fast_res = bus.FUN3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    accept   = (state_q == S_IDLE) && bus.START && !bus.FLUSH;
  end

  // 33x33 signed product; the low 64 bits are all any FUN3 needs.
  always_comb begin
    mul_a   = {(op_q != F_MULHU) & a_q[XLEN-1], a_q};
    mul_b   = {((op_q == F_MUL) || (op_q == F_MULH)) & b_q[XLEN-1], b_q};
    ext_a   = {{(XLEN-1){mul_a[XLEN]}}, mul_a};
    ext_b   = {{(XLEN-1){mul_b[XLEN]}}, mul_b};
    prod    = ext_a * ext_b;
    mul_res = (op_q == F_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk_i       (CLK),
    .rst_i       (RST),
    .load_i      (accept && bus.FUN3[2]),
    .step_i      (state_q == S_DIV),
    .dividend_i  (dvd_mag),
    .divisor_i   (dsr_mag),
    .quotient_o  (quot),
    .remainder_o (rem),
    .last_o      (div_last)
  );

  always_comb begin
    q_fix   = (!op_q[0] && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quot : quot;
    r_fix   = (!op_q[0] && a_q[XLEN-1]) ? -rem : rem;
    fix_res = op_q[1] ? r_fix : q_fix;
    case (state_q)
      S_IDLE:  result_d = fast_res;
      S_MUL:   result_d = mul_res;
      S_FIX:   result_d = fix_res;
      default: result_d = result_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      op_q     <= F_MUL;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.FLUSH) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.START) begin
          op_q <= fun3_e'(bus.FUN3);
          a_q  <= bus.RS1;
          b_q  <= bus.RS2;
          if (!bus.FUN3[2]) begin
            state_q <= S_MUL;
            busy_q  <= 1'b1;
          end else if (fast) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            result_q <= result_d;
          end else begin
            state_q <= S_DIV;
            busy_q  <= 1'b1;
          end
        end
        S_MUL: begin
          state_q  <= S_DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          result_q <= result_d;
        end
        S_DIV: if (div_last) state_q <= S_FIX;
        S_FIX: begin
          state_q  <= S_DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          result_q <= result_d;
        end
        S_DONE: if (!bus.STALL) begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.RESULT = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, randomized ops
// against an arithmetic reference model, and hand-written flush/stall/reset sequences.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  mul_div_unit_if bus();

  mul_div_unit #(.XLEN(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ea  = (f != 3'd3) ? {{32{a[31]}}, a} : {32'd0, a};
    eb  = (f <= 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p   = ea * eb;
    case (f)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 2;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issues one op from an IDLE cycle; poke != 0 pulses START with a mul in that cycle.
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int poke);
    int   lat;
    int   busy_bad;
    logic seen;
    bus.START = 1'b1; bus.FUN3 = f; bus.RS1 = a; bus.RS2 = b;
    @(posedge clk); #1;
    bus.START = 1'b0; bus.RS1 = $urandom; bus.RS2 = $urandom;
    lat = 0; busy_bad = 0; seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (poke != 0 && lat == poke) begin
        bus.START = 1'b1; bus.FUN3 = 3'b000;
      end else bus.START = 1'b0;
      if (bus.DONE) seen = 1'b1;
      if (bus.BUSY !== (!bus.DONE && exp_lat > 1)) busy_bad++;
    end
    bus.START = 1'b0;
    check({nm, " result"}, bus.RESULT, exp);
    check({nm, " latency"}, lat, exp_lat);
    check({nm, " busy pattern"}, busy_bad, 0);
    @(negedge clk);
    check({nm, " idle after"}, {30'd0, bus.BUSY, bus.DONE}, 32'd0);
  endtask

  initial begin
    logic [31:0] old_res;
    logic [2:0]  f;
    logic [31:0] a, b;
    int          bad;

    vecs[0]  = '{"mulh min*min",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2};
    vecs[1]  = '{"mul min*min",    3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 2};
    vecs[2]  = '{"mulhsu -1*max",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2};
    vecs[3]  = '{"mulhu max*max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
    vecs[4]  = '{"div -7/2",       3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
    vecs[5]  = '{"rem -7%2",       3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34};
    vecs[6]  = '{"divu 5/0",       3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[7]  = '{"remu 5%0",       3'd7, 32'd5,         32'd0,         32'd5,         1};
    vecs[8]  = '{"div overflow",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[9]  = '{"rem overflow",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[10] = '{"divu 100/7",     3'd5, 32'd100,       32'd7,         32'd14,        34};
    vecs[11] = '{"remu 100%7",     3'd7, 32'd100,       32'd7,         32'd2,         34};
    vecs[12] = '{"rem 7%-2",       3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         34};
    vecs[13] = '{"div 0/-1",       3'd4, 32'd0,         32'hFFFF_FFFF, 32'd0,         34};

    bus.START = 1'b0; bus.FUN3 = 3'd0; bus.RS1 = '0; bus.RS2 = '0;
    bus.STALL = 1'b0; bus.FLUSH = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset BUSY", {31'd0, bus.BUSY}, 32'd0);
    check("reset DONE", {31'd0, bus.DONE}, 32'd0);
    check("reset RESULT", bus.RESULT, 32'd0);

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d f%0d", i, f), f, a, b, ref_result(f, a, b), ref_lat(f, a, b), 0);
    end

    // START during DIV must be ignored.
    run_op("div start ignored", 3'd5, 32'd100, 32'd7, 32'd14, 34, 5);

    // FLUSH in DIV cycle 10 kills the op without DONE and keeps RESULT.
    old_res = bus.RESULT;
    bus.START = 1'b1; bus.FUN3 = 3'd4; bus.RS1 = 32'd1000; bus.RS2 = 32'd3;
    @(posedge clk); #1 bus.START = 1'b0;
    repeat (10) @(negedge clk);
    bus.FLUSH = 1'b1;
    @(posedge clk); #1 bus.FLUSH = 1'b0;
    @(negedge clk);
    check("flush BUSY", {31'd0, bus.BUSY}, 32'd0);
    check("flush DONE", {31'd0, bus.DONE}, 32'd0);
    check("flush RESULT kept", bus.RESULT, old_res);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) bad++;
    end
    check("flush no DONE", bad, 0);
    run_op("mul 3x4 after flush", 3'd0, 32'd3, 32'd4, 32'd12, 2, 0);

    // FLUSH and START together: nothing accepted.
    bus.START = 1'b1; bus.FLUSH = 1'b1; bus.FUN3 = 3'd0; bus.RS1 = 32'd9; bus.RS2 = 32'd9;
    @(posedge clk); #1 bus.START = 1'b0; bus.FLUSH = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0 || bus.RESULT !== 32'd12) bad++;
    end
    check("flush beats start", bad, 0);

    // DONE held while STALL is high.
    bus.STALL = 1'b1;
    bus.START = 1'b1; bus.FUN3 = 3'd0; bus.RS1 = 32'd7; bus.RS2 = 32'd6;
    @(posedge clk); #1 bus.START = 1'b0;
    repeat (2) @(negedge clk);
    check("stall DONE up", {31'd0, bus.DONE}, 32'd1);
    check("stall RESULT", bus.RESULT, 32'd42);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b0 || bus.RESULT !== 32'd42) bad++;
    end
    check("stall held", bad, 0);
    bus.STALL = 1'b0;
    @(negedge clk);
    check("stall release", {30'd0, bus.BUSY, bus.DONE}, 32'd0);
    check("stall RESULT after", bus.RESULT, 32'd42);

    // Reset in the middle of a divide.
    bus.START = 1'b1; bus.FUN3 = 3'd4; bus.RS1 = 32'hFFFF_FFF9; bus.RS2 = 32'd2;
    @(posedge clk); #1 bus.START = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst mid-div outputs", {bus.RESULT[29:0], bus.BUSY, bus.DONE}, 32'd0);
    check("rst mid-div RESULT", bus.RESULT, 32'd0);
    run_op("div after reset", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
